// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main controller for the multicycle MIPS datapath. Sequences
//            fetch, decode, address, memory, execute and writeback steps.
//            Memory states wait on a ready handshake guarded by a wait-state
//            timeout. Unsupported opcodes and bus timeouts enter an absorbing
//            TRAP state and set sticky flags.
// Macro    : MULTICYCLE_CTRL_BNE_EN
//            When defined, adds the BNE opcode (000101) and its state.
//            When undefined, that opcode traps as illegal.
// Ports    : clk, reset (sync, active-high), opcode[5:0], zero, mem_ready
//            pc_en, iord, we_mem, ir_write, reg_dst, mem_to_reg, we_regf,
//            alu_src_a, alu_src_b[1:0], aluop[1:0], pc_src[1:0],
//            illegal, bus_error, state[STATE_W-1:0]
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               we_mem,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               we_regf,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         aluop,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic               bus_error,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
`ifdef MULTICYCLE_CTRL_BNE_EN
    , S_BNE  = 4'd13
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic             timeout_hit;
  logic             is_wait;

  // Last permitted waiting cycle with no ready; mem_ready takes priority.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == TMO_LAST);
  assign is_wait     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH) ? S_DECODE :
                    (state_q == S_MEMRD) ? S_MEMWB  : S_FETCH;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only LW/SW reach MEMADR; the IR still holds the opcode.
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    // Counter runs only while lingering in a wait state; any transition or
    // a ready cycle (which always transitions) clears it.
    if (is_wait && (state_d == state_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Output decode. While reset is high, outputs look like FETCH with the
  // ready-gated enables forced low.
  state_t st_out;
  logic   ready_g;
  logic   pc_write;
  logic   branch;
`ifdef MULTICYCLE_CTRL_BNE_EN
  logic   branch_ne;
`endif

  assign st_out  = reset ? S_FETCH : state_q;
  assign ready_g = mem_ready & ~reset;

  always_comb begin
    iord       = 1'b0;
    we_mem     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    we_regf    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
    branch_ne  = 1'b0;
`endif
    case (st_out)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = ready_g;
        pc_write  = ready_g;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        we_regf    = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        we_mem = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        we_regf = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: we_regf = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_src    = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
  assign pc_en = pc_write | (branch & zero);
`endif

  logic [3:0] state_bits;
  assign state_bits = state_q;
  assign state      = STATE_W'(state_bits);
  assign illegal    = illegal_q;
  assign bus_error  = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
//            Each instruction is expanded into its expected list of steps,
//            memory steps repeated for their wait cycles, and every cycle's
//            state, outputs and sticky flags are compared to a table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, we_mem, ir_write, reg_dst, mem_to_reg, we_regf, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_src;
  logic       illegal, bus_error;
  logic [3:0] state;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .we_mem(we_mem), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .we_regf(we_regf),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  logic [13:0] dut_vec;
  assign dut_vec = {pc_en, iord, we_mem, ir_write, reg_dst, mem_to_reg, we_regf,
                    alu_src_a, alu_src_b, aluop, pc_src};

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_ill  = 1'b0;
  bit exp_bus  = 1'b0;

  // Output table for each state, straight from the controller's step list.
  function automatic logic [13:0] exp_out(input int st, input logic mr, input logic z);
    logic pcw, br, bne, io, wm, irw, rd, m2r, wr, sa;
    logic [1:0] sb, op, ps;
    pcw = 0; br = 0; bne = 0; io = 0; wm = 0; irw = 0; rd = 0; m2r = 0; wr = 0; sa = 0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      0:  begin sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; wr = 1; end
      5:  begin io = 1; wm = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; wr = 1; end
      8:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: wr = 1;
      11: begin ps = 2'b10; pcw = 1; end
      13: begin sa = 1; op = 2'b01; ps = 2'b01; bne = 1; end
      default: ;
    endcase
    return {pcw | (br & z) | (bne & ~z), io, wm, irw, rd, m2r, wr, sa, sb, op, ps};
  endfunction

  // Called just after a falling edge: drive inputs, compare, advance a cycle.
  task automatic check_cycle(input int exp_st, input logic [5:0] opc, input logic z,
                             input logic mr, input string tag);
    logic [13:0] e;
    opcode = opc; zero = z; mem_ready = mr;
    #1;
    e = exp_out(exp_st, mr, z);
    n_checks++;
    if (state !== 4'(exp_st)) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
    end
    n_checks++;
    if (dut_vec !== e) begin
      n_fail++;
      $display("FAIL %s outputs (st %0d): got %b expected %b", tag, exp_st, dut_vec, e);
    end
    n_checks++;
    if ({illegal, bus_error} !== {exp_ill, exp_bus}) begin
      n_fail++;
      $display("FAIL %s flags ill/bus: got %b%b expected %b%b", tag, illegal, bus_error, exp_ill, exp_bus);
    end
    @(negedge clk);
  endtask

  // Holds reset two cycles with mem_ready high; returns with reset released.
  task automatic do_reset(input string tag);
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
    @(negedge clk);
    @(negedge clk);
    #1;
    exp_ill = 1'b0; exp_bus = 1'b0;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset state/flags: got %0d %b%b expected 0 00", tag, state, illegal, bus_error);
    end
    n_checks++;
    if (dut_vec !== exp_out(0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL %s outputs in reset: got %b expected %b", tag, dut_vec, exp_out(0, 1'b0, 1'b0));
    end
    reset = 1'b0;
  endtask

  // One instruction from FETCH. wf/wm = wait cycles in FETCH / memory step.
  // zmode 0/1 fixes zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] opc, input int zmode, input int wf,
                           input int wm, input string tag);
    int path[$];
    int reps;
    logic mr, z;
    case (opc)
      OP_R:    path = '{0, 1, 6, 7};
      OP_LW:   path = '{0, 1, 2, 3, 4};
      OP_SW:   path = '{0, 1, 2, 5};
      OP_BEQ:  path = '{0, 1, 8};
      OP_ADDI: path = '{0, 1, 9, 10};
      OP_J:    path = '{0, 1, 11};
      default: path = '{0, 1, 13};
    endcase
    foreach (path[k]) begin
      reps = (path[k] == 0) ? wf + 1 : (path[k] == 3 || path[k] == 5) ? wm + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        if (path[k] == 0 || path[k] == 3 || path[k] == 5) mr = (r == reps - 1);
        else mr = 1'($urandom_range(0, 1));
        z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        check_cycle(path[k], opc, z, mr, tag);
      end
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
    run_instr(OP_J, 2, 0, 0, "reset_then_j");
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 2, 0, 0, "lw");
  endtask

  task automatic test_sw_wait();
    run_instr(OP_SW, 2, 0, 3, "sw_wait3");
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 1, 0, 0, "beq_taken");
    run_instr(OP_BEQ, 0, 1, 0, "beq_not_taken");
  endtask

  task automatic test_illegal(input logic [5:0] opc, input string tag);
    do_reset(tag);
    check_cycle(0, opc, 1'b0, 1'b1, tag);
    check_cycle(1, opc, 1'b0, 1'b1, tag);
    exp_ill = 1'b1;
    repeat (10) check_cycle(12, opc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    do_reset(tag);
  endtask

  task automatic test_timeout();
    do_reset("tmo_fetch");
    repeat (4) check_cycle(0, OP_R, 1'b0, 1'b0, "tmo_fetch");
    exp_bus = 1'b1;
    repeat (3) check_cycle(12, OP_R, 1'b0, 1'($urandom_range(0, 1)), "tmo_fetch_trap");
    do_reset("tmo_memrd");
    check_cycle(0, OP_LW, 1'b0, 1'b1, "tmo_memrd");
    check_cycle(1, OP_LW, 1'b0, 1'b1, "tmo_memrd");
    check_cycle(2, OP_LW, 1'b0, 1'b1, "tmo_memrd");
    repeat (4) check_cycle(3, OP_LW, 1'b0, 1'b0, "tmo_memrd");
    exp_bus = 1'b1;
    repeat (2) check_cycle(12, OP_LW, 1'b0, 1'b1, "tmo_memrd_trap");
    do_reset("tmo_edge");
    run_instr(OP_R, 2, 3, 0, "ready_on_4th_fetch");
    run_instr(OP_LW, 2, 0, 3, "ready_on_4th_memrd");
  endtask

  task automatic test_reset_mid();
    check_cycle(0, OP_SW, 1'b0, 1'b1, "reset_mid");
    check_cycle(1, OP_SW, 1'b0, 1'b1, "reset_mid");
    check_cycle(2, OP_SW, 1'b0, 1'b1, "reset_mid");
    check_cycle(5, OP_SW, 1'b0, 1'b0, "reset_mid");
    do_reset("reset_mid");
    run_instr(OP_ADDI, 2, 0, 0, "after_reset_mid");
  endtask

  task automatic test_bne();
`ifdef MULTICYCLE_CTRL_BNE_EN
    run_instr(OP_BNE, 0, 0, 0, "bne_taken");
    run_instr(OP_BNE, 1, 0, 0, "bne_not_taken");
`else
    test_illegal(OP_BNE, "bne_absent");
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops[$];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`ifdef MULTICYCLE_CTRL_BNE_EN
    ops.push_back(OP_BNE);
`endif
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      run_instr(op, 2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal(6'b111111, "illegal_3f");
    test_timeout();
    test_reset_mid();
    test_bne();
    do_reset("pre_random");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle main controller: a Moore/Mealy FSM that sequences the multicycle MIPS datapath through fetch, decode, address, memory, execute and writeback steps. It is driven by the instruction opcode and ALU zero flag. It generates every datapath enable and mux select except the ALU function, which the existing ALU decoder derives from `aluop`. It extends single-cycle decoding with a memory ready handshake, a wait-state timeout, and a sticky trap on illegal opcodes or bus errors.

## Interface
- `MEM_TIMEOUT`, 16: max cycles to wait for `mem_ready` in a memory state; 0 disables the timeout.
- `STATE_W`, 4: width of the `state` debug output.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction[31:26] from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_en` out 1: PC register enable, `pc_write | (branch & zero)` (plus BNE term, see Configuration).
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `we_mem` out 1: memory write enable.
- `ir_write` out 1: instruction register enable.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = Data register, 0 = ALUOut.
- `we_regf` out 1: register file write enable.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `aluop` out 2: 00 add, 01 sub, 10 funct-defined.
- `pc_src` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: sticky flag for an unsupported opcode.
- `bus_error` out 1: sticky flag for a memory timeout.
- `state` out `STATE_W`: current state encoding.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12, BNE 13 (present only with the macro).
- Output defaults: every output not listed for a state is 0.
- FETCH
  - Outputs: alu_src_b=01; ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE
  - Outputs: alu_src_b=11.
  - Next state: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP, anything else→TRAP with `illegal`=1.
- MEMADR
  - Outputs: alu_src_a=1, alu_src_b=10.
  - Next state: LW→MEMRD, SW→MEMWR.
- MEMRD
  - Outputs: iord=1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB
  - Outputs: mem_to_reg=1, we_regf=1.
  - Next state: FETCH.
- MEMWR
  - Outputs: iord=1; we_mem=1 held every cycle until mem_ready.
  - Next state: FETCH.
- EXEC
  - Outputs: alu_src_a=1, aluop=10.
  - Next state: ALUWB.
- ALUWB
  - Outputs: reg_dst=1, we_regf=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: alu_src_a=1, aluop=01, pc_src=01, branch=1 (internal).
  - Next state: FETCH.
- ADDIEX
  - Outputs: alu_src_a=1, alu_src_b=10.
  - Next state: ADDIWB.
- ADDIWB
  - Outputs: we_regf=1.
  - Next state: FETCH.
- JUMP
  - Outputs: pc_src=10, pc_write=1.
  - Next state: FETCH.
- TRAP
  - All enables are 0 and the state is absorbing; only `reset` exits it.
- Wait counter
  - Cleared on entry to FETCH, MEMRD or MEMWR and on every mem_ready.
  - Increments each cycle spent waiting, saturating.
  - When MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT−1 while mem_ready=0, the next state is TRAP with `bus_error`=1.
  - Net effect: at most MEM_TIMEOUT waiting cycles.
  - Counter width is $clog2(MEM_TIMEOUT+1), minimum 1.
- Priority: when mem_ready and a timeout coincide, mem_ready wins and no error is raised.

## Timing
- Reset: state=FETCH, counter=0, illegal=0, bus_error=0.
- During and after reset all outputs follow FETCH:
  - alu_src_b=01.
  - ir_write, pc_write and pc_en equal mem_ready, gated to 0 while reset=1.
  - Every other output is 0.
- Reset mid-access abandons the access and returns to FETCH the next cycle.
- Outputs are combinational from state. The only Mealy terms are ir_write/pc_write gating by mem_ready and pc_en's dependence on zero.
- Latency with zero-wait memory (mem_ready tied 1):
  - LW: 5 cycles.
  - SW, R, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
- Each memory wait cycle adds 1 to that count.
- State register updates only on the rising edge of `clk`.

## Configuration
- Macro: `MULTICYCLE_CTRL_BNE_EN`.
- Defined:
  - Opcode 000101 (BNE) goes DECODE→BNE→FETCH.
  - BNE state outputs match BRANCH, but drive internal branch_ne=1 instead of branch.
  - pc_en = pc_write | (branch & zero) | (branch_ne & ~zero).
- Undefined:
  - BNE state and logic are absent.
  - Opcode 000101 traps as illegal.

## Test plan
- Reset with mem_ready=1:
  - state=0, illegal=0, bus_error=0.
  - pc_en=ir_write=0 while reset is high, and 1 in the first cycle after reset deasserts.
- LW (100011), mem_ready=1 throughout: state sequence 0,1,2,3,4,0; we_regf=1 and mem_to_reg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEMWR: we_mem=1 for 4 consecutive cycles with iord=1, then state 0, bus_error=0.
- BEQ in BRANCH:
  - zero=1 gives pc_en=1, pc_src=01, aluop=01.
  - zero=0 gives pc_en=0.
- Opcode 111111: DECODE→TRAP (12) with illegal=1; all enables stay 0 for 10 cycles; reset restores FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH:
  - TRAP with bus_error=1 after 4 waiting cycles.
  - Rerun with mem_ready=1 arriving on the 4th cycle: DECODE, no error.
- With the macro defined, opcode 000101: zero=0 gives pc_en=1 in state 13. Without the macro, the same opcode gives illegal=1.
